// File: rtl/dram_ctrl_pkg.sv
// Shared types for the DRAM controller data path: SIPO capture FSM states and
// the counter-width helper used by the capture stage.
package dram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_t;

  // Bit count 0..width inclusive, so the counter can represent a full word.
  function automatic int sipo_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-word valid/ready holding register for the SIPO capture stage. Carries the
// captured word plus its parity_err flag; flags a dropped word on overflow.
module sipo_hold_reg
  #(parameter int WIDTH = 8)
  (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             word_perr,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             parity_err,
    output logic             out_valid,
    output logic             overflow
  );

  logic             accept;
  logic [WIDTH:0]   hold_q;

  // The slot is free when empty or when its current word leaves this cycle.
  assign accept = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hold_q    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= load && !accept;
      if (load && accept) begin
        hold_q    <= {word_perr, word};
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign data_out   = hold_q[WIDTH-1:0];
  assign parity_err = hold_q[WIDTH];

endmodule

// File: rtl/sipo_capture.sv
// Serial-in/parallel-out capture stage, LSB first, framed by frame_start/bit_valid.
// Define PARITY_EN to expect an even-parity bit after every word.
module sipo_capture
  import dram_ctrl_pkg::*;
  #(parameter int WIDTH = 8)
  (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             parity_err
  );

  localparam int                 CNT_W    = sipo_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   ONE      = CNT_W'(1);

  sipo_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  shift_q;

  logic              start_bit;
  logic              shift_bit;
  logic              word_done;
  logic [WIDTH-1:0]  word;
  logic              word_perr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bit_valid && frame_start) state_nxt = SHIFT;
      SHIFT:  if (bit_valid && !frame_start && cnt == LAST_IDX)
`ifdef PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = IDLE;
`endif
`ifdef PARITY_EN
      PARITY: if (bit_valid) state_nxt = frame_start ? SHIFT : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // A frame_start bit restarts a word from any state; data bits only shift in SHIFT.
  always_comb begin
    start_bit = bit_valid && frame_start;
    shift_bit = bit_valid && !frame_start && (state == SHIFT);
    word_done = 1'b0;
    word      = shift_q;
    word_perr = 1'b0;
    case (state)
      SHIFT: begin
`ifndef PARITY_EN
        if (shift_bit && cnt == LAST_IDX) begin
          word_done = 1'b1;
          word      = {serial_in, shift_q[WIDTH-1:1]};
        end
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_valid && !frame_start) begin
          word_done = 1'b1;
          word_perr = ^{shift_q, serial_in};
        end
      end
`endif
      default: ;
    endcase
  end

  // NOTE: the shift register is reset even though it holds data, because a
  // partial word must not survive reset into the next frame.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shift_q <= '0;
      cnt     <= '0;
    end else begin
      if (start_bit)
        shift_q <= {serial_in, {(WIDTH-1){1'b0}}};
      else if (shift_bit)
        shift_q <= {serial_in, shift_q[WIDTH-1:1]};

      if (start_bit)      cnt <= ONE;
      else if (word_done) cnt <= '0;
      else if (shift_bit) cnt <= cnt + ONE;
    end
  end

  sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst_b      (rst_b),
    .load       (word_done),
    .word       (word),
    .word_perr  (word_perr),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .parity_err (parity_err),
    .out_valid  (out_valid),
    .overflow   (overflow)
  );

endmodule
